lock_code_entry: RTL and testbench

//  Passcode-entry controller for the VGA board lock. Collects four hex digits from the switches, one per

---
 rtl/lock_code_entry.sv | 181 ++++++++++++++++++
 tb/tb_lock_code_entry.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lock_code_entry.sv
// lock_code_entry: four-digit passcode entry FSM with registered 7-seg display codes; LOCK_LOCKOUT_EN adds failure lockout
module lock_code_entry #(
  parameter logic [15:0] PASSCODE       = 16'h1234,
  parameter logic [4:0]  CODE_DASH      = 5'h1F,
  parameter logic [4:0]  CODE_ERR       = 5'h1E,
  parameter int          OPEN_CYCLES    = 50000000,
  parameter int          ERR_CYCLES     = 25000000,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 250000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw_digit,
  input  logic        btn_enter,
  input  logic        btn_clear,
  output logic [19:0] big_bin,
  output logic        unlocked,
  output logic        error,
  output logic        alarm
);
  localparam int T_OE = OPEN_CYCLES > ERR_CYCLES ? OPEN_CYCLES : ERR_CYCLES;
`ifdef LOCK_LOCKOUT_EN
  localparam int T_MAX = T_OE > LOCKOUT_CYCLES ? T_OE : LOCKOUT_CYCLES;
`else
  localparam int T_MAX = T_OE;
`endif
  localparam int TW = T_MAX > 1 ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] ERR_LAST = TW'(ERR_CYCLES - 1);
  localparam logic [19:0] DASHES = {4{CODE_DASH}};
  localparam logic [19:0] ERRS = {4{CODE_ERR}};

  if (OPEN_CYCLES < 1 || ERR_CYCLES < 1 || MAX_FAIL < 1 || LOCKOUT_CYCLES < 1) begin : g_cfg_check
    $error("lock_code_entry: cycle and failure-count parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    ENTRY0, ENTRY1, ENTRY2, ENTRY3, CHECK, OPEN, ERROR
`ifdef LOCK_LOCKOUT_EN
    , LOCKOUT
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [19:0]   big_bin_q, big_bin_d;
  logic          unlocked_q, unlocked_d, error_q, error_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          btn_enter_q, btn_clear_q;
  logic [1:0]    idx;
  logic [3:0]    sh5;
  logic          enter_rise, clear_rise;

  assign enter_rise = btn_enter & ~btn_enter_q;
  assign clear_rise = btn_clear & ~btn_clear_q;
  assign idx = state_q[1:0];
  assign sh5 = {idx, 2'b00} + 4'(idx);
  assign big_bin = big_bin_q;
  assign unlocked = unlocked_q;
  assign error = error_q;

`ifdef LOCK_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  logic [FW-1:0] fail_q, fail_d;
  logic          alarm_q, alarm_d;
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  // Next state, digit/display updates and registered output values
  always_comb begin
    state_d = state_q;
    digits_d = digits_q;
    big_bin_d = big_bin_q;
`ifdef LOCK_LOCKOUT_EN
    fail_d = fail_q;
`endif
    case (state_q)
      ENTRY0, ENTRY1, ENTRY2, ENTRY3: begin
        if (clear_rise) begin
          state_d = ENTRY0;
          digits_d = '0;
          big_bin_d = DASHES;
        end else if (enter_rise) begin
          state_d = state_t'(state_q + 3'd1);
          digits_d = (digits_q & ~(16'hF000 >> {idx, 2'b00})) | ({sw_digit, 12'h000} >> {idx, 2'b00});
          big_bin_d = (big_bin_q & ~(20'hF8000 >> sh5)) | ({1'b0, sw_digit, 15'h0000} >> sh5);
        end
      end
      CHECK: begin
        if (digits_q == PASSCODE) begin
          state_d = OPEN;
`ifdef LOCK_LOCKOUT_EN
          fail_d = '0;
`endif
        end else begin
          state_d = ERROR;
          big_bin_d = ERRS;
`ifdef LOCK_LOCKOUT_EN
          fail_d = (int'(fail_q) < MAX_FAIL) ? fail_q + 1'b1 : fail_q;
          if (int'(fail_q) + 1 == MAX_FAIL) state_d = LOCKOUT;
`endif
        end
      end
      OPEN: begin
        if (clear_rise || timer_q == OPEN_LAST) begin
          state_d = ENTRY0;
          digits_d = '0;
          big_bin_d = DASHES;
        end
      end
      ERROR: begin
        if (timer_q == ERR_LAST) begin
          state_d = ENTRY0;
          digits_d = '0;
          big_bin_d = DASHES;
        end
      end
`ifdef LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = ENTRY0;
          digits_d = '0;
          big_bin_d = DASHES;
          fail_d = '0;
        end
      end
`endif
      default: begin
        state_d = ENTRY0;
        digits_d = '0;
        big_bin_d = DASHES;
      end
    endcase
    timer_d = (state_d != state_q || !state_q[2]) ? '0 : timer_q + 1'b1;
    unlocked_d = state_d == OPEN;
    error_d = state_d == ERROR;
`ifdef LOCK_LOCKOUT_EN
    error_d = error_d || state_d == LOCKOUT;
    alarm_d = state_d == LOCKOUT;
`endif
  end

  // State, datapath and edge-detect registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ENTRY0;
      digits_q <= '0;
      big_bin_q <= DASHES;
      unlocked_q <= 1'b0;
      error_q <= 1'b0;
      timer_q <= '0;
      btn_enter_q <= 1'b0;
      btn_clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      big_bin_q <= big_bin_d;
      unlocked_q <= unlocked_d;
      error_q <= error_d;
      timer_q <= timer_d;
      btn_enter_q <= btn_enter;
      btn_clear_q <= btn_clear;
    end
  end

`ifdef LOCK_LOCKOUT_EN
  // Failure counter and alarm output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      fail_q <= fail_d;
      alarm_q <= alarm_d;
    end
  end
`endif
endmodule

// File: tb/tb_lock_code_entry.sv
// tb_lock_code_entry: table-driven scoreboard bench for the passcode entry controller
module tb_lock_code_entry;
  localparam logic [19:0] D = 20'hFFFFF;
  localparam logic [19:0] E = 20'hF7BDE;
`ifdef LOCK_LOCKOUT_EN
  localparam int LOCK_LEN = 16;
  localparam logic ALM = 1'b1;
`else
  localparam int LOCK_LEN = 4;
  localparam logic ALM = 1'b0;
`endif

  typedef struct {
    logic        rst_n, en, cl;
    logic [3:0]  sw;
    logic [19:0] bb;
    logic        u, e, a;
    int          n;
  } vec_t;

  vec_t        tbl[$];
  logic [22:0] sb[$];
  int          checks = 0, failures = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic [3:0]  sw_digit = 4'h0;
  logic [19:0] big_bin;
  logic        unlocked, error, alarm;

  always #5 clk = ~clk;

  lock_code_entry #(
    .OPEN_CYCLES(8), .ERR_CYCLES(4), .MAX_FAIL(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_digit(sw_digit), .btn_enter(btn_enter),
    .btn_clear(btn_clear), .big_bin(big_bin), .unlocked(unlocked), .error(error), .alarm(alarm)
  );

  function automatic logic [19:0] disp(input logic [15:0] d, input int n);
    logic [19:0] r = '0;
    for (int k = 0; k < 4; k++) r = {r[14:0], (k < n) ? {1'b0, d[15-4*k -: 4]} : 5'h1F};
    return r;
  endfunction

  task automatic add(input logic r, input logic en, input logic cl, input logic [3:0] sw,
                     input logic [19:0] bb, input logic u, input logic e, input logic a, input int n);
    vec_t v;
    v.rst_n = r; v.en = en; v.cl = cl; v.sw = sw; v.bb = bb; v.u = u; v.e = e; v.a = a; v.n = n;
    tbl.push_back(v);
  endtask

  task automatic add_code(input logic [15:0] d);
    for (int k = 0; k < 4; k++) begin
      add(1'b1, 1'b1, 1'b0, d[15-4*k -: 4], disp(d, k + 1), 1'b0, 1'b0, 1'b0, 1);
      if (k < 3) add(1'b1, 1'b0, 1'b0, d[15-4*k -: 4], disp(d, k + 1), 1'b0, 1'b0, 1'b0, 1);
    end
  endtask

  task automatic add_error(input int len, input logic a);
    add(1'b1, 1'b0, 1'b0, 4'h0, E, 1'b0, 1'b1, a, 1);
    add(1'b1, 1'b0, 1'b1, 4'h0, E, 1'b0, 1'b1, a, 1);
    add(1'b1, 1'b0, 1'b0, 4'h0, E, 1'b0, 1'b1, a, len - 2);
    add(1'b1, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic add_open();
    add_code(16'h1234);
    add(1'b1, 1'b0, 1'b0, 4'h0, 20'h08864, 1'b1, 1'b0, 1'b0, 8);
    add(1'b1, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    logic [22:0] exp;
    add(1'b0, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 2);
    add_open();
    add_code(16'h1235);
    add_error(4, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'h7, disp(16'h7000, 1), 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b0, 4'h9, disp(16'h7000, 1), 1'b0, 1'b0, 1'b0, 19);
    add(1'b1, 1'b0, 1'b0, 4'h9, disp(16'h7000, 1), 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b1, 4'h3, D, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 4'h3, D, 1'b0, 1'b0, 1'b0, 1);
    add_code(16'h1234);
    add(1'b1, 1'b0, 1'b0, 4'h0, 20'h08864, 1'b1, 1'b0, 1'b0, 3);
    add(1'b1, 1'b0, 1'b1, 4'h0, D, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 1);
    for (int w = 0; w < 2; w++) begin
      add_code(16'h5555);
      add_error(4, 1'b0);
    end
    add_code(16'h5555);
    add_error(LOCK_LEN, ALM);
    add_open();
    add(1'b1, 1'b1, 1'b0, 4'h1, disp(16'h1200, 1), 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 4'h1, disp(16'h1200, 1), 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b0, 4'h2, disp(16'h1200, 2), 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 4'h2, disp(16'h1200, 2), 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 2);
`ifdef LOCK_LOCKOUT_EN
    for (int w = 0; w < 2; w++) begin
      add_code(16'h5555);
      add_error(4, 1'b0);
    end
    add_code(16'h5555);
    add(1'b1, 1'b0, 1'b0, 4'h0, E, 1'b0, 1'b1, 1'b1, 5);
`else
    add_code(16'h5555);
    add(1'b1, 1'b0, 1'b0, 4'h0, E, 1'b0, 1'b1, 1'b0, 2);
`endif
    add(1'b0, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 4'h0, D, 1'b0, 1'b0, 1'b0, 1);
    add_code(16'h5555);
    add_error(4, 1'b0);
    add_open();

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        rst_n = tbl[i].rst_n;
        btn_enter = tbl[i].en;
        btn_clear = tbl[i].cl;
        sw_digit = tbl[i].sw;
        sb.push_back({tbl[i].bb, tbl[i].u, tbl[i].e, tbl[i].a});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if (big_bin !== exp[22:3]) begin
          failures++;
          $display("FAIL vec%0d.%0d big_bin: got=%h expected=%h", i, j, big_bin, exp[22:3]);
        end
        checks++;
        if ({unlocked, error, alarm} !== exp[2:0]) begin
          failures++;
          $display("FAIL vec%0d.%0d {unlocked,error,alarm}: got=%b expected=%b", i, j, {unlocked, error, alarm}, exp[2:0]);
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
